// File: rtl/indicator_led_ctrl.sv
// indicator_led_ctrl: status-LED driver for the stopwatch/watch top level.
//   led[3:0]             time-unit / mode pairs, flashed to 4'hF on a switch change
//   led[4+NUM_DIGITS-1:4] one LED per adjustable digit; the selected one blinks
// Optional feature macro: INDICATOR_BLINK_EN. When it is defined, the selected
// digit LED blinks at BLINK_HZ. When it is undefined, that LED is steadily on
// and no prescaler is built.
// The led output is registered. It reflects the inputs sampled at the same edge.
module indicator_led_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int BLINK_HZ     = 2,
  parameter int FLASH_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sec_hour,
  input  logic                    sw_w,
  input  logic [NUM_DIGITS-1:0]   adjust_digit_sel,
  output logic [3+NUM_DIGITS:0]   led
);

  localparam int FLASH_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES - 1);

  typedef enum logic {IDLE, FLASH} state_t;

  state_t                state_q, state_d;
  logic [FLASH_W-1:0]    flash_cnt_q, flash_cnt_d;
  logic                  primed_q;
  logic                  sec_prev_q, sw_prev_q;
  logic [3+NUM_DIGITS:0] led_q, led_d;

  logic                  sw_change;
  logic                  flash_on;
  logic                  blink_on;
  logic                  sel_zero, sel_onehot;
  logic [NUM_DIGITS-1:0] digit_d;

`ifdef INDICATOR_BLINK_EN
  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] sel_prev_q;

  // Blink prescaler. A new selection restarts the on-phase at once.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (adjust_digit_sel != sel_prev_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Prescaler, phase and previous-selection registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      sel_prev_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      sel_prev_q <= adjust_digit_sel;
    end
  end

  assign blink_on = phase_d;
`else
  // Without blinking the clock-rate parameters have no effect.
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{CLK_HZ, BLINK_HZ};
  assign blink_on         = 1'b1;
`endif

  // Flash FSM next state and the complete LED image for this edge.
  always_comb begin
    // NOTE: each signal gets a default first, so every path assigns it and no latch is inferred.
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    flash_on    = 1'b0;
    // A change on both switches in the same cycle is one trigger.
    sw_change   = primed_q && ((sec_hour != sec_prev_q) || (sw_w != sw_prev_q));

    case (state_q)
      IDLE: begin
        if (sw_change) begin
          state_d     = FLASH;
          flash_cnt_d = FLASH_LOAD;
          flash_on    = 1'b1;
        end
      end
      FLASH: begin
        // A change on the terminal cycle retriggers instead of exiting.
        if (sw_change) begin
          flash_cnt_d = FLASH_LOAD;
          flash_on    = 1'b1;
        end else if (flash_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          flash_cnt_d = flash_cnt_q - FLASH_W'(1);
          flash_on    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    sel_zero   = (adjust_digit_sel == '0);
    sel_onehot = !sel_zero &&
                 ((adjust_digit_sel & (adjust_digit_sel - NUM_DIGITS'(1))) == '0);
    if (sel_zero)
      digit_d = '0;
    else if (sel_onehot)
      digit_d = blink_on ? adjust_digit_sel : '0;
    else
      digit_d = '1;  // multi-hot select is a fault: light every digit steadily

    led_d = {digit_d, flash_on ? 4'hF : {sw_w, ~sw_w, sec_hour, ~sec_hour}};
  end

  // State, switch history and LED output registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      flash_cnt_q <= '0;
      primed_q    <= 1'b0;
      sec_prev_q  <= 1'b0;
      sw_prev_q   <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
      primed_q    <= 1'b1;
      sec_prev_q  <= sec_hour;
      sw_prev_q   <= sw_w;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_indicator_led_ctrl.sv
// Directed bench for indicator_led_ctrl with NUM_DIGITS=4, HALF=4, FLASH_CYCLES=3.
module tb_indicator_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_hour;
  logic       sw_w;
  logic [3:0] sel;
  logic [7:0] led;

  int tests = 0;
  int fails = 0;

  indicator_led_ctrl #(
    .NUM_DIGITS  (4),
    .CLK_HZ      (8),
    .BLINK_HZ    (1),
    .FLASH_CYCLES(3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sec_hour        (sec_hour),
    .sw_w            (sw_w),
    .adjust_digit_sel(sel),
    .led             (led)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Selected digit LED state n edges after the selection edge.
  function automatic logic on_at(input int n);
`ifdef INDICATOR_BLINK_EN
    return ((n / 4) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    rst = 1'b0; sec_hour = 1'b1; sw_w = 1'b0; sel = 4'b0000;
    step();
    check("reset_led0", led, 8'h00);
    step();
    check("reset_led1", led, 8'h00);

    // Release: normal mode image, no flash out of reset.
    rst = 1'b1;
    step();
    check("release", led, 8'b0000_0110);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_spurious_flash", led, 8'b0000_0110);
    end

    // sw_w 0->1: flash for three edges, then the new mode image.
    sw_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flash", led, 8'h0F);
    end
    step();
    check("flash_end", led, 8'b0000_1010);

    // Retrigger at edge k+1: flash runs to k+3, normal from k+4.
    sw_w = 1'b0;
    step();
    check("retrig_k", led, 8'h0F);
    sw_w = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("retrig_flash", led, 8'h0F);
    end
    step();
    check("retrig_end", led, 8'b0000_1010);

    // Blink on digit 2.
    sel = 4'b0100;
    for (int n = 0; n < 14; n++) begin
      step();
      check("blink_d2", led, {on_at(n) ? 4'b0100 : 4'b0000, 4'b1010});
    end

    // Switch to digit 0 during the off phase: lit at once for a full half.
    sel = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      step();
      check("blink_d0", led, {on_at(n) ? 4'b0001 : 4'b0000, 4'b1010});
    end

    // Multi-hot fault: all digit LEDs steady.
    sel = 4'b0110;
    for (int n = 0; n < 9; n++) begin
      step();
      check("multihot", led, 8'hFA);
    end
    sel = 4'b0000;
    step();
    check("sel_zero", led, 8'h0A);

    // Digit 3 over 16 edges.
    sel = 4'b1000;
    for (int n = 0; n < 16; n++) begin
      step();
      check("digit3", led, {on_at(n) ? 4'b1000 : 4'b0000, 4'b1010});
    end

    // Reset in the middle of a flash.
    sec_hour = 1'b0;
    step();
    check("pre_reset_flash", led[3:0], 8'h0F);
    rst = 1'b0;
    step();
    check("reset_midflash", led, 8'h00);
    rst = 1'b1;
    step();
    check("release2", led, 8'b1000_1001);
    step();
    check("release2_noflash", led[3:0], 8'b0000_1001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/indicator_led_ctrl.md
# indicator_led_ctrl

Parametrised status-LED driver for the stopwatch/watch top level, the successor to the fixed 7-LED indicator. It shows the time-unit and stopwatch/watch mode as LED pairs, plus one LED per adjustable digit that blinks while that digit is selected for adjustment. Any mode-switch change flashes all four mode LEDs for a fixed number of cycles. It sits beside the FND controller and is driven by the debounced switches and the adjust-digit selector.

## Interface
- NUM_DIGITS, 4: width of the one-hot adjust selector; one digit LED per bit
- CLK_HZ, 100_000_000: clock frequency in Hz
- BLINK_HZ, 2: full blink rate of the selected digit LED; HALF = CLK_HZ/(2*BLINK_HZ), must be ≥1
- FLASH_CYCLES, 50_000_000: length of the mode-change flash in clock cycles, ≥1

- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-low
- sec_hour  in  1  time-unit switch (sw[0])
- sw_w  in  1  stopwatch/watch mode switch (sw[1])
- adjust_digit_sel  in  NUM_DIGITS  one-hot adjust digit select; all-zero means no adjust
- led  out  4+NUM_DIGITS  registered LED drive

## Operation
- Normal mode LEDs: led[0]=~sec_hour, led[1]=sec_hour, led[2]=~sw_w, led[3]=sw_w.
- Digit LEDs led[4+i], i=0..NUM_DIGITS-1:
  - sel all-zero: all off.
  - sel exactly one-hot at bit i: led[4+i] follows the blink phase; the other digit LEDs are off.
  - sel multi-hot (fault): all digit LEDs steadily on, no blink.
- Blink prescaler: counter 0..HALF-1, width $clog2(HALF) (min 1). It wraps at HALF-1 and toggles phase there. Phase=1 means on.
- Any change of adjust_digit_sel from its last sampled value clears the counter and sets phase=1 in that cycle. The new digit is therefore lit immediately for a full HALF.
- Flash FSM, states IDLE and FLASH:
  - IDLE→FLASH when the sampled sec_hour or sw_w differs from its previous sample and primed=1. This loads flash_cnt=FLASH_CYCLES-1.
  - FLASH: led[3:0]=4'hF. flash_cnt decrements each cycle; FLASH→IDLE when flash_cnt==0.
  - A further change during FLASH reloads flash_cnt (retrigger). The state stays FLASH.
- primed: 0 at reset, set to 1 on the first cycle after reset. While primed=0, the previous-sample registers load without raising a flash, so there is no spurious flash out of reset.
- Simultaneous change of both switches is a single trigger. A change on the cycle flash_cnt hits 0 retriggers instead of exiting.

## Timing
- Reset (rst=0 at a clk edge): led=0, state=IDLE, flash_cnt=0, prescaler=0, phase=1, primed=0, previous samples=0.
- Reset asserted mid-flash or mid-blink takes effect at the next edge and overrides everything.
- Latency: led reflects inputs sampled at the same edge. Input change at edge k is visible after edge k (1 cycle).
- Flash: change sampled at edge k gives led[3:0]=4'hF for edges k..k+FLASH_CYCLES-1. Normal values resume from edge k+FLASH_CYCLES.
- Blink: a selected LED is on for HALF cycles, then off for HALF cycles, repeating, counted from the selection edge.
- Digit LEDs are independent of the flash state.

## Configuration
- INDICATOR_BLINK_EN defined: the selected digit LED blinks as above.
- INDICATOR_BLINK_EN undefined: the selected digit LED is steadily on. The prescaler and phase logic are not built. All other behaviour is unchanged.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_HZ=8, BLINK_HZ=1 (HALF=4), FLASH_CYCLES=3.
- Reset with sec_hour=1, sw_w=0, sel=0, then release -> led=0 during reset; afterwards led=8'b0000_0110 with no flash.
- Toggle sw_w 0→1 at edge k -> led[3:0]=4'hF for edges k..k+2; led[3:0]=4'b1010 from edge k+3.
- Toggle sw_w again at edge k+1 of an active flash -> flash extends to edge k+3, normal from edge k+4.
- sel=4'b0100 (BLINK_EN on) -> led[6] on 4 cycles, off 4, on 4; other digit LEDs 0. Switching to 4'b0001 mid-off-phase -> led[4] on immediately for 4 cycles, led[6]=0.
- sel=4'b0110 -> led[7:4]=4'hF steady. sel=0 -> led[7:4]=0.
- Build without INDICATOR_BLINK_EN, sel=4'b1000 -> led[7] steadily 1 for ≥16 cycles. Drive rst=0 mid-flash -> led=0 next edge.
